// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the program counter and the link register
//   (or a small return-address stack), drives a synchronous instruction ROM
//   and presents INS / INS_addr / INS_valid to the instruction decoder.
//   A taken jump/call/return costs exactly one bubble; stall freezes the stage.
//
// Optional feature (macro RETURN_STACK_EN):
//   defined   : link becomes a STACK_DEPTH-entry circular LIFO, linkreg shows
//               the top entry, stack_err flags overflow/underflow (sticky).
//   undefined : single link register, stack_err tied low.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stall             hold fetch state and outputs
//   load_pc           redirect request from decoder
//   PC_source         0: target = new_pc, 1: target = link (return)
//   new_pc            jump/call target
//   load_linkreg      call: write new_linkreg into link
//   new_linkreg       return address
//   imem_addr         ROM read address (= pc_q)
//   imem_en           ROM read enable (= ~stall), ROM holds output when low
//   imem_data         ROM data, one-cycle latency
//   INS, INS_addr     instruction and its address
//   INS_valid         INS is architecturally live
//   linkreg           current link value (top of stack when enabled)
//   stack_err         sticky over/underflow flag
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int                  ADDR_W      = 16,
  parameter int                  INS_W       = 21,
  parameter logic [ADDR_W-1:0]   RESET_PC    = 16'h0000,
  parameter logic [INS_W-1:0]    NOP_WORD    = 21'h1F0000,
  parameter int                  STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              load_pc,
  input  logic              PC_source,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              load_linkreg,
  input  logic [ADDR_W-1:0] new_linkreg,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INS_W-1:0]  imem_data,
  output logic [INS_W-1:0]  INS,
  output logic [ADDR_W-1:0] INS_addr,
  output logic              INS_valid,
  output logic [ADDR_W-1:0] linkreg,
  output logic              stack_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
  logic              ins_valid_q, ins_valid_d;
  logic              squash_q, squash_d;

  logic              redirect;
  logic              call;
  logic [ADDR_W-1:0] ret_target;
  logic [ADDR_W-1:0] target;

  // Decoder requests only count against a live instruction; squash_q marks the
  // bubble slot so a request sampled there can never be acted upon.
  assign redirect = load_pc & ins_valid_q & ~squash_q & ~stall;
  assign call     = load_linkreg & ins_valid_q & ~squash_q & ~stall;
  assign target   = PC_source ? ret_target : new_pc;

  assign imem_addr = pc_q;
  assign imem_en   = ~stall;
  assign INS_addr  = ins_addr_q;
  assign INS_valid = ins_valid_q;
  // The ROM output register holds under stall, so INS holds with it.
  assign INS       = ins_valid_q ? imem_data : NOP_WORD;

  // Next-state for PC and the decoder-facing pipeline registers.
  always_comb begin
    pc_d        = pc_q;
    ins_addr_d  = ins_addr_q;
    ins_valid_d = ins_valid_q;
    squash_d    = squash_q;
    if (stall) begin
      pc_d        = pc_q;
      ins_addr_d  = ins_addr_q;
      ins_valid_d = ins_valid_q;
      squash_d    = squash_q;
    end else begin
      // The word being latched by the ROM on a redirect edge is the
      // sequential successor; it is the bubble and must not be live.
      squash_d    = redirect;
      ins_valid_d = ~redirect;
      ins_addr_d  = pc_q;
      if (redirect) begin
        pc_d = target;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  // PC and pipeline register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ins_addr_q  <= RESET_PC;
      ins_valid_q <= 1'b0;
      squash_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ins_addr_q  <= ins_addr_d;
      ins_valid_q <= ins_valid_d;
      squash_q    <= squash_d;
    end
  end

`ifdef RETURN_STACK_EN
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STACK_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              push, pop, empty, full;
  logic [PTR_W-1:0]  top_inc, top_dec;

  // Push has priority if the decoder ever asserts call and return together.
  assign push    = call;
  assign pop     = redirect & PC_source & ~call;
  assign empty   = (cnt_q == CNT_W'(0));
  assign full    = (cnt_q == CNT_W'(STACK_DEPTH));
  assign top_inc = (top_q == PTR_W'(STACK_DEPTH - 1)) ? PTR_W'(0) : top_q + PTR_W'(1);
  assign top_dec = (top_q == PTR_W'(0)) ? PTR_W'(STACK_DEPTH - 1) : top_q - PTR_W'(1);

  assign linkreg    = empty ? ADDR_W'(0) : stk_q[top_q];
  assign ret_target = empty ? RESET_PC   : stk_q[top_q];
  assign stack_err  = err_q;

  // Return-stack next state: circular push overwrites the oldest entry when full.
  always_comb begin
    stk_d = stk_q;
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      stk_d[top_inc] = new_linkreg;
      top_d          = top_inc;
      if (full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        top_d = top_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      err_d = err_q;
    end
  end

  // Return-stack storage, pointer, fill count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_q[i] <= ADDR_W'(0);
      end
      top_q <= PTR_W'(0);
      cnt_q <= CNT_W'(0);
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic [ADDR_W-1:0] link_q, link_d;

  assign linkreg    = link_q;
  assign ret_target = link_q;
  assign stack_err  = 1'b0;

  // Single link register: written by a call, left untouched by a return.
  always_comb begin
    link_d = link_q;
    if (call) begin
      link_d = new_linkreg;
    end else begin
      link_d = link_q;
    end
  end

  // Link register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_q <= ADDR_W'(0);
    end else begin
      link_q <= link_d;
    end
  end
`endif

endmodule

`default_nettype wire
